// File: rtl/mux_pkg.sv
// mux_pkg: shared default sizes and mode encodings for the channel muxes
package mux_pkg;
  localparam int N_DEF = 8;
  localparam int W_DEF = 8;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
endpackage

// File: rtl/mux_nx1.sv
// mux_nx1: combinational N:1 selector over packed channel data
module mux_nx1 #(
  parameter int N = 8,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic [N*W-1:0] data,
  input  logic [SW-1:0]  idx,
  output logic [W-1:0]   y
);
  assign y = data[idx*W +: W];
endmodule

// File: rtl/rr_mux_nx1.sv
// rr_mux_nx1: registered N:1 mux with fixed or round-robin valid/ready arbitration
module rr_mux_nx1
  import mux_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_ch,
  output logic          out_valid,
  input  logic          out_ready
);
  logic [SW-1:0] ptr;
  logic [SW-1:0] rr_grant;
  logic [SW-1:0] grant;
  logic [SW-1:0] cand;
  logic [W-1:0]  sel_data;
  logic          hit;
  logic          load_en;
  logic          xfer;
  always_comb begin
    rr_grant = ptr;
    cand = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr + SW'(k);
      if (in_valid[cand]) rr_grant = cand;
    end
  end
  assign grant = (mode == MODE_RR) ? rr_grant : sel;
  assign hit = (mode == MODE_FIXED) ? in_valid[sel] : |in_valid;
  assign load_en = !out_valid || out_ready;
  assign xfer = !rst && load_en && hit;
  assign in_ready = xfer ? (N'(1) << grant) : '0;
  mux_nx1 #(.N(N), .W(W)) u_sel (
    .data(in_data),
    .idx (grant),
    .y   (sel_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= '0;
    end else if (load_en) begin
      out_valid <= hit;
      if (hit) begin
        out_data <= sel_data;
        out_ch <= grant;
        if (mode == MODE_RR) ptr <= grant + SW'(1);
      end
    end
  end
endmodule

// File: tb/tb_rr_mux_nx1.sv
// tb_rr_mux_nx1: directed self-checking bench for rr_mux_nx1
module tb_rr_mux_nx1;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rr_mux_nx1 #(.N(8), .W(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .sel(sel),
    .out_data(out_data),
    .out_ch(out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [2:0] c);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_ch"}, 32'(out_ch), 32'(c));
  endtask
  initial begin
    int rr_seq[5] = '{2, 7, 0, 2, 7};
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
    rst = 1'b1;
    in_valid = 8'hFF;
    mode = 1'b1;
    sel = 3'd0;
    out_ready = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 8'h00, 3'd0);
    chk("reset_ready", 32'(in_ready), 32'h00);
    rst = 1'b0;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'h01);
    tick();
    chk_out("rr_first", 1'b1, 8'hA0, 3'd0);
    mode = 1'b0;
    sel = 3'd5;
    #1;
    chk("fixed_ready", 32'(in_ready), 32'h20);
    tick();
    chk_out("fixed_1", 1'b1, 8'hA5, 3'd5);
    chk("fixed_ready2", 32'(in_ready), 32'h20);
    tick();
    chk_out("fixed_2", 1'b1, 8'hA5, 3'd5);
    mode = 1'b1;
    in_valid = 8'b1000_0101;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_ready", 32'(in_ready), 32'h1 << rr_seq[i]);
      tick();
      chk_out("rr_seq", 1'b1, 8'hA0 + 8'(rr_seq[i]), 3'(rr_seq[i]));
    end
    in_valid = 8'h40;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("idle_ready", 32'(in_ready), 32'h40);
      tick();
      chk_out("idle_skip", 1'b1, 8'hA6, 3'd6);
    end
    in_valid = 8'b1000_0101;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'h00);
      tick();
      chk_out("bp_hold", 1'b1, 8'hA6, 3'd6);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h80);
    tick();
    chk_out("bp_release", 1'b1, 8'hA7, 3'd7);
    in_valid = 8'h00;
    #1;
    chk("empty_ready", 32'(in_ready), 32'h00);
    tick();
    chk_out("empty", 1'b0, 8'hA7, 3'd7);
    in_valid = 8'b1000_0101;
    tick();
    chk_out("pre_rst_load", 1'b1, 8'hA0, 3'd0);
    out_ready = 1'b0;
    tick();
    chk_out("pre_rst_hold", 1'b1, 8'hA0, 3'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'h00);
    tick();
    chk_out("mid_rst", 1'b0, 8'h00, 3'd0);
    rst = 1'b0;
    in_valid = 8'h00;
    tick();
    chk_out("no_stale", 1'b0, 8'h00, 3'd0);
    in_valid = 8'hFF;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'h01);
    tick();
    chk_out("post_rst", 1'b1, 8'hA0, 3'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_mux_nx1.md
# rr_mux_nx1

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It selects either a fixed channel (`sel`) or scans channels round-robin, skipping idle ones, and holds the selection in a one-entry output register. It is the sequential successor to the fixed 8:1 combinational mux tree and sits between multiple producer streams and a single consumer.

## Interface
- `N`, default 8: channel count; power of two, ≥ 2.
- `W`, default 8: data width per channel.
- `SW`, default `$clog2(N)`: select/channel-index width; derived, not overridden.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  N*W  packed channel data; channel i at bits [i*W +: W].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready; at most one bit high per cycle.
- `mode`  in  1  0 = fixed select, 1 = round-robin scan.
- `sel`  in  SW  channel used when `mode` = 0.
- `out_data`  out  W  registered selected data.
- `out_ch`  out  SW  index of the channel that produced `out_data`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts word.

## Operation
- Output register states: EMPTY (`out_valid` = 0) and FULL (`out_valid` = 1).
- `load_en = !out_valid || out_ready`. The register accepts a new word whenever empty or being drained in the same cycle, giving full throughput of 1 word/cycle.
- Grant, fixed mode: `grant = sel`; `hit = in_valid[sel]`.
- Grant, round-robin mode: `grant` is the first i with `in_valid[i]` = 1, searching ptr, ptr+1, … N-1, 0, … ptr-1 (mod N); `hit` = any `in_valid`.
- `in_ready[i] = load_en && hit && (i == grant)`; all zero otherwise. `in_ready` is combinational from `in_valid`, `mode`, `sel`, `out_valid`, `out_ready`. A transfer occurs on channel i when `in_valid[i] && in_ready[i]`.
- On transfer: `out_data <= in_data[grant]`, `out_ch <= grant`, `out_valid <= 1`.
- On `load_en && !hit`: `out_valid <= 0`. `out_data` and `out_ch` hold their last values.
- FULL && !`out_ready`: the register holds `out_data`/`out_ch` stable. No `in_ready` is asserted.
- Round-robin pointer `ptr` (SW bits): on a transfer in mode 1, `ptr <= (grant + 1) mod N`, wrapping N-1 → 0. `ptr` is unchanged in mode 0 and on cycles with no transfer.
- `mode`/`sel` are sampled every cycle. Changes affect only the next grant and never alter a word already held.
- Reset (any cycle, including mid-transfer): `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `ptr` = 0, all `in_ready` = 0 during `rst`. An in-flight held word is discarded.

## Timing
- Latency: input transfer at edge k → `out_valid`/`out_data` visible after edge k; consumed by the consumer at earliest edge k+1.
- Sustained throughput: 1 word/cycle with `out_ready` held high.
- No combinational path from `in_data` to `out_data`. The only combinational path from `out_ready` goes to `in_ready`.
- Simultaneous drain and load in one cycle: the old word is consumed and the new word is registered at the same edge.

## Structure
- Shared package `mux_pkg`: the default `N`/`W` constants and the `MODE_FIXED` = 0 / `MODE_RR` = 1 encodings.
- Sub-module `mux_nx1` (parameters `N`, `W`): purely combinational N:1 selector taking packed data and a SW-bit index. The top level instantiates it once for the data path. The round-robin priority search and registers stay in `rr_mux_nx1`.

## Test plan
- Reset: assert `rst` with all inputs valid → `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `in_ready` = 0; first post-reset RR grant goes to channel 0.
- Fixed mode: `mode` = 0, `sel` = 5, `in_valid` = 8'hFF, `in_data[5]` = 8'hA5, `out_ready` = 1 → only `in_ready[5]` high; next cycle `out_data` = 8'hA5, `out_ch` = 5, one word per cycle.
- Round-robin fairness and wrap: `mode` = 1, `in_valid` = 8'b1000_0101, `out_ready` = 1 → `out_ch` sequence 0, 2, 7, 0, 2, 7…
- Idle skipping: only channel 6 valid → repeated grants to channel 6 with `ptr` = 7 → wrap search still returns 6.
- Backpressure: `out_ready` = 0 for 4 cycles while FULL → `out_data`/`out_ch` stable, all `in_ready` = 0; release → held word drains and the next word loads in the same cycle.
- Reset mid-operation: `rst` asserted while FULL with `out_ready` = 0 → `out_valid` drops to 0 next cycle, `ptr` returns to 0, and no stale word reappears afterwards.
